// File: rtl/rv_decode_ctrl_if.sv
// Connects rv_decode_ctrl to fetch, the register file, the ALU and data memory.
// The master side is the decoder; the slave side is the surrounding pipeline.
interface rv_decode_ctrl_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 8,
    parameter int CNT_W    = 32
);
    logic                instr_valid;
    logic [31:0]         instr_data;
    logic [XLEN-1:0]     instr_pc;
    logic                instr_ready;
    logic [4:0]          rf_rs1_addr;
    logic [4:0]          rf_rs2_addr;
    logic [XLEN-1:0]     rf_rs1_data;
    logic [XLEN-1:0]     rf_rs2_data;
    logic                rf_we;
    logic [4:0]          rf_wr_addr;
    logic [XLEN-1:0]     rf_wr_data;
    logic [ALU_OP_W-1:0] alu_opcode;
    logic [XLEN-1:0]     alu_op_a;
    logic [XLEN-1:0]     alu_op_b;
    logic [XLEN-1:0]     alu_result;
    logic                mem_req;
    logic                mem_we;
    logic [1:0]          mem_size;
    logic [XLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic                mem_ack;
    logic [XLEN-1:0]     mem_rdata;
    logic                pc_jump_en;
    logic [XLEN-1:0]     pc_target;
    logic                illegal_instr;
    logic [CNT_W-1:0]    instr_retired;

    modport master (
        input  instr_valid, instr_data, instr_pc, rf_rs1_data, rf_rs2_data,
               alu_result, mem_ack, mem_rdata,
        output instr_ready, rf_rs1_addr, rf_rs2_addr, rf_we, rf_wr_addr, rf_wr_data,
               alu_opcode, alu_op_a, alu_op_b, mem_req, mem_we, mem_size, mem_addr,
               mem_wdata, pc_jump_en, pc_target, illegal_instr, instr_retired
    );

    modport slave (
        output instr_valid, instr_data, instr_pc, rf_rs1_data, rf_rs2_data,
               alu_result, mem_ack, mem_rdata,
        input  instr_ready, rf_rs1_addr, rf_rs2_addr, rf_we, rf_wr_addr, rf_wr_data,
               alu_opcode, alu_op_a, alu_op_b, mem_req, mem_we, mem_size, mem_addr,
               mem_wdata, pc_jump_en, pc_target, illegal_instr, instr_retired
    );
endinterface

// File: rtl/rv_decode_ctrl.sv
// Multi-cycle RV32I decode/control FSM: one instruction per handshake, sequenced
// IDLE -> DECODE -> READ -> EXEC -> (MEM) -> WB, with RF, ALU and memory driven from registers.
module rv_decode_ctrl #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    rv_decode_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_READ, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [3:0] {K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JAL, K_JALR,
                              K_BRANCH, K_LOAD, K_STORE} kind_t;

    state_t              state_reg, state_next;
    kind_t               kind_reg, kind_dec;
    logic [31:0]         instr_reg;
    logic [XLEN-1:0]     pc_reg, imm_reg, rs1_val_reg, rs2_val_reg;
    logic [XLEN-1:0]     result_reg, target_reg, alu_a_reg, alu_b_reg;
    logic [XLEN-1:0]     mem_addr_reg, mem_wdata_reg, load_ext;
    logic [4:0]          rs1_reg, rs2_reg, rd_reg;
    logic [2:0]          funct3_reg;
    logic [ALU_OP_W-1:0] alu_op_reg, alu_op_dec;
    logic [1:0]          mem_size_reg;
    logic                mem_we_reg, jump_reg, illegal_dec, branch_taken, writes_rd;
    logic [CNT_W-1:0]    retired_reg;
    logic [31:0]         imm_dec;
    logic [6:0]          opcode, funct7;
    logic [2:0]          funct3;

    assign opcode = instr_reg[6:0];
    assign funct3 = instr_reg[14:12];
    assign funct7 = instr_reg[31:25];

    // funct3 (plus the funct7[5] alternate bit) to the ALU operation encoding
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_code = alt ? 4'd1 : 4'd0;
            3'b001:  alu_code = 4'd5;
            3'b010:  alu_code = 4'd6;
            3'b011:  alu_code = 4'd7;
            3'b100:  alu_code = 4'd4;
            3'b101:  alu_code = alt ? 4'd8 : 4'd9;
            3'b110:  alu_code = 4'd3;
            default: alu_code = 4'd2;
        endcase
    endfunction

    always_comb begin
        kind_dec    = K_OP;
        imm_dec     = '0;
        alu_op_dec  = '0;
        illegal_dec = 1'b0;
        case (opcode)
            7'b0110011: begin
                kind_dec   = K_OP;
                alu_op_dec = ALU_OP_W'(alu_code(funct3, funct7[5]));
                if (funct7 == 7'b0100000)
                    illegal_dec = !(funct3 == 3'b000 || funct3 == 3'b101);
                else
                    illegal_dec = (funct7 != 7'b0000000);
            end
            7'b0010011: begin
                kind_dec   = K_OPIMM;
                imm_dec    = {{20{instr_reg[31]}}, instr_reg[31:20]};
                alu_op_dec = ALU_OP_W'(alu_code(funct3, (funct3 == 3'b101) && funct7[5]));
                if (funct3 == 3'b001)
                    illegal_dec = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal_dec = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            7'b0110111: begin
                kind_dec = K_LUI;
                imm_dec  = {instr_reg[31:12], 12'b0};
            end
            7'b0010111: begin
                kind_dec = K_AUIPC;
                imm_dec  = {instr_reg[31:12], 12'b0};
            end
            7'b1101111: begin
                kind_dec = K_JAL;
                imm_dec  = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                            instr_reg[20], instr_reg[30:21], 1'b0};
            end
            7'b1100111: begin
                kind_dec    = K_JALR;
                imm_dec     = {{20{instr_reg[31]}}, instr_reg[31:20]};
                illegal_dec = (funct3 != 3'b000);
            end
            7'b1100011: begin
                kind_dec    = K_BRANCH;
                imm_dec     = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                               instr_reg[30:25], instr_reg[11:8], 1'b0};
                illegal_dec = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            7'b0000011: begin
                kind_dec    = K_LOAD;
                imm_dec     = {{20{instr_reg[31]}}, instr_reg[31:20]};
                illegal_dec = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            7'b0100011: begin
                kind_dec    = K_STORE;
                imm_dec     = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
                illegal_dec = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
            end
            default: illegal_dec = 1'b1;
        endcase
    end

    always_comb begin
        case (funct3_reg)
            3'b000:  branch_taken = (bus.rf_rs1_data == bus.rf_rs2_data);
            3'b001:  branch_taken = (bus.rf_rs1_data != bus.rf_rs2_data);
            3'b100:  branch_taken = ($signed(bus.rf_rs1_data) <  $signed(bus.rf_rs2_data));
            3'b101:  branch_taken = ($signed(bus.rf_rs1_data) >= $signed(bus.rf_rs2_data));
            3'b110:  branch_taken = (bus.rf_rs1_data <  bus.rf_rs2_data);
            default: branch_taken = (bus.rf_rs1_data >= bus.rf_rs2_data);
        endcase
    end

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = XLEN'($signed(bus.mem_rdata[7:0]));
            3'b001:  load_ext = XLEN'($signed(bus.mem_rdata[15:0]));
            3'b100:  load_ext = XLEN'(bus.mem_rdata[7:0]);
            3'b101:  load_ext = XLEN'(bus.mem_rdata[15:0]);
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = illegal_dec ? S_IDLE : S_READ;
            S_READ:   state_next = S_EXEC;
            S_EXEC:   state_next = (kind_reg == K_LOAD || kind_reg == K_STORE) ? S_MEM : S_WB;
            S_MEM:    if (bus.mem_ack) state_next = S_WB;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_reg      <= K_OP;
            instr_reg     <= '0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            rs1_val_reg   <= '0;
            rs2_val_reg   <= '0;
            result_reg    <= '0;
            target_reg    <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            funct3_reg    <= '0;
            alu_op_reg    <= '0;
            mem_size_reg  <= '0;
            mem_we_reg    <= 1'b0;
            jump_reg      <= 1'b0;
            retired_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (bus.instr_valid) begin
                    instr_reg <= bus.instr_data;
                    pc_reg    <= bus.instr_pc;
                end
                S_DECODE: begin
                    rs1_reg    <= instr_reg[19:15];
                    rs2_reg    <= instr_reg[24:20];
                    rd_reg     <= instr_reg[11:7];
                    funct3_reg <= funct3;
                    kind_reg   <= kind_dec;
                    imm_reg    <= XLEN'($signed(imm_dec));
                    alu_op_reg <= alu_op_dec;
                end
                S_READ: begin
                    rs1_val_reg <= bus.rf_rs1_data;
                    rs2_val_reg <= bus.rf_rs2_data;
                    alu_a_reg   <= bus.rf_rs1_data;
                    // shift-immediates carry funct7 in imm[11:5]; only the shamt goes to the ALU
                    if (kind_reg == K_OP)              alu_b_reg <= bus.rf_rs2_data;
                    else if (funct3_reg[1:0] == 2'b01) alu_b_reg <= XLEN'(imm_reg[4:0]);
                    else                               alu_b_reg <= imm_reg;
                    jump_reg <= (kind_reg == K_BRANCH) ? branch_taken
                                                       : (kind_reg == K_JAL || kind_reg == K_JALR);
                end
                S_EXEC: case (kind_reg)
                    K_OP, K_OPIMM: result_reg <= bus.alu_result;
                    K_LUI:         result_reg <= imm_reg;
                    K_AUIPC:       result_reg <= pc_reg + imm_reg;
                    K_JAL: begin
                        result_reg <= pc_reg + XLEN'(4);
                        target_reg <= pc_reg + imm_reg;
                    end
                    K_JALR: begin
                        result_reg <= pc_reg + XLEN'(4);
                        target_reg <= (rs1_val_reg + imm_reg) & {{(XLEN-1){1'b1}}, 1'b0};
                    end
                    K_BRANCH:      target_reg <= pc_reg + imm_reg;
                    default: begin
                        mem_addr_reg  <= rs1_val_reg + imm_reg;
                        mem_wdata_reg <= rs2_val_reg;
                        mem_we_reg    <= (kind_reg == K_STORE);
                        mem_size_reg  <= funct3_reg[1:0];
                    end
                endcase
                S_MEM: if (bus.mem_ack) result_reg <= load_ext;
                S_WB:  retired_reg <= retired_reg + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign writes_rd = (kind_reg != K_BRANCH) && (kind_reg != K_STORE);

    assign bus.instr_ready   = (state_reg == S_IDLE);
    assign bus.illegal_instr = (state_reg == S_DECODE) && illegal_dec;
    assign bus.rf_we         = (state_reg == S_WB) && writes_rd && (rd_reg != 5'd0);
    assign bus.pc_jump_en    = (state_reg == S_WB) && jump_reg;
    assign bus.mem_req       = (state_reg == S_MEM);
    assign bus.rf_rs1_addr   = rs1_reg;
    assign bus.rf_rs2_addr   = rs2_reg;
    assign bus.rf_wr_addr    = rd_reg;
    assign bus.rf_wr_data    = result_reg;
    assign bus.alu_opcode    = alu_op_reg;
    assign bus.alu_op_a      = alu_a_reg;
    assign bus.alu_op_b      = alu_b_reg;
    assign bus.mem_we        = mem_we_reg;
    assign bus.mem_size      = mem_size_reg;
    assign bus.mem_addr      = mem_addr_reg;
    assign bus.mem_wdata     = mem_wdata_reg;
    assign bus.pc_target     = target_reg;
    assign bus.instr_retired = retired_reg;
endmodule

// File: tb/tb_rv_decode_ctrl.sv
// Scoreboard bench for rv_decode_ctrl: each issued instruction pushes its expected
// outcome, which is popped and compared once the decoder returns to IDLE.
module tb_rv_decode_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv_decode_ctrl_if #(.XLEN(32), .ALU_OP_W(8), .CNT_W(32)) bus ();
    rv_decode_ctrl #(.XLEN(32), .ALU_OP_W(8), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        illegal;
        logic        we;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        jump;
        logic [31:0] target;
        int          ready_cyc;
        int          mem_cycles;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        chk_alu;
        logic [7:0]  alu_op;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rf_mem [32];
    int          checks = 0;
    int          errors = 0;
    int          exp_retired = 0;

    // register file and ALU behaviour seen by the decoder
    always_comb begin
        bus.rf_rs1_data = rf_mem[bus.rf_rs1_addr];
        bus.rf_rs2_data = rf_mem[bus.rf_rs2_addr];
    end

    always_comb begin
        case (bus.alu_opcode)
            8'd0:    bus.alu_result = bus.alu_op_a + bus.alu_op_b;
            8'd1:    bus.alu_result = bus.alu_op_a - bus.alu_op_b;
            8'd2:    bus.alu_result = bus.alu_op_a & bus.alu_op_b;
            8'd3:    bus.alu_result = bus.alu_op_a | bus.alu_op_b;
            8'd4:    bus.alu_result = bus.alu_op_a ^ bus.alu_op_b;
            8'd5:    bus.alu_result = bus.alu_op_a << bus.alu_op_b[4:0];
            8'd6:    bus.alu_result = {31'b0, $signed(bus.alu_op_a) < $signed(bus.alu_op_b)};
            8'd7:    bus.alu_result = {31'b0, bus.alu_op_a < bus.alu_op_b};
            8'd8:    bus.alu_result = $unsigned($signed(bus.alu_op_a) >>> bus.alu_op_b[4:0]);
            8'd9:    bus.alu_result = bus.alu_op_a >> bus.alu_op_b[4:0];
            default: bus.alu_result = 32'h0;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic ill, input logic we, input logic [4:0] wa,
                                    input logic [31:0] wd, input logic jmp, input logic [31:0] tgt,
                                    input int rdy, input int memc, input logic mwe,
                                    input logic [1:0] msz, input logic [31:0] ma,
                                    input logic [31:0] mwd, input logic ca, input logic [7:0] aop);
        exp_t e;
        e.illegal = ill; e.we = we; e.wr_addr = wa; e.wr_data = wd; e.jump = jmp; e.target = tgt;
        e.ready_cyc = rdy; e.mem_cycles = memc; e.mem_we = mwe; e.mem_size = msz;
        e.mem_addr = ma; e.mem_wdata = mwd; e.chk_alu = ca; e.alu_op = aop;
        return e;
    endfunction

    // Called on a falling edge with the decoder idle; returns on the falling edge it is idle again.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic [31:0] pc,
                             input int mem_wait, input logic [31:0] rdata);
        exp_t        e;
        int          we_n = 0, we_cyc = -1, jmp_n = 0, jmp_cyc = -1, ill_n = 0, ill_cyc = -1;
        int          req_n = 0, mem_cnt = 0, ready_cyc = -1;
        logic [4:0]  wa = '0;
        logic [31:0] wd = '0, tgt = '0, ma = '0, mwd = '0;
        logic        mwe = 1'b0;
        logic [1:0]  msz = '0;
        logic [7:0]  aop = '0;
        check_val({name, ".ready_in"}, 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_data  = instr;
        bus.instr_pc    = pc;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        for (int k = 1; k <= 40 && ready_cyc < 0; k++) begin
            @(negedge clk);
            if (bus.rf_we) begin
                we_n++; we_cyc = k; wa = bus.rf_wr_addr; wd = bus.rf_wr_data;
                if (wa != 5'd0) rf_mem[wa] = wd;
            end
            if (bus.pc_jump_en) begin jmp_n++; jmp_cyc = k; tgt = bus.pc_target; end
            if (bus.illegal_instr) begin ill_n++; ill_cyc = k; end
            if (k == 3) aop = bus.alu_opcode;
            if (bus.mem_req) begin
                req_n++;
                if (mem_cnt == mem_wait) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
                    ma = bus.mem_addr; mwe = bus.mem_we; msz = bus.mem_size; mwd = bus.mem_wdata;
                end else begin
                    bus.mem_ack = 1'b0;
                end
                mem_cnt++;
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (bus.instr_ready) ready_cyc = k;
        end
        e = exp_q.pop_front();
        check_val({name, ".ready_cyc"}, 32'(ready_cyc), 32'(e.ready_cyc));
        check_val({name, ".illegal"}, 32'(ill_n), 32'(e.illegal));
        if (e.illegal) check_val({name, ".illegal_cyc"}, 32'(ill_cyc), 32'd1);
        check_val({name, ".rf_we"}, 32'(we_n), 32'(e.we));
        if (e.we) begin
            check_val({name, ".wr_addr"}, 32'(wa), 32'(e.wr_addr));
            check_val({name, ".wr_data"}, wd, e.wr_data);
            check_val({name, ".we_cyc"}, 32'(we_cyc), 32'(e.ready_cyc - 1));
        end
        check_val({name, ".jump"}, 32'(jmp_n), 32'(e.jump));
        if (e.jump) begin
            check_val({name, ".target"}, tgt, e.target);
            check_val({name, ".jump_cyc"}, 32'(jmp_cyc), 32'(e.ready_cyc - 1));
        end
        check_val({name, ".mem_req_cycles"}, 32'(req_n), 32'(e.mem_cycles));
        if (e.mem_cycles > 0) begin
            check_val({name, ".mem_addr"}, ma, e.mem_addr);
            check_val({name, ".mem_we"}, 32'(mwe), 32'(e.mem_we));
            check_val({name, ".mem_size"}, 32'(msz), 32'(e.mem_size));
            if (e.mem_we) check_val({name, ".mem_wdata"}, mwd, e.mem_wdata);
        end
        if (e.chk_alu) check_val({name, ".alu_opcode"}, 32'(aop), 32'(e.alu_op));
        if (!e.illegal) exp_retired++;
        check_val({name, ".retired"}, bus.instr_retired, 32'(exp_retired));
        $display("TXN %-8s instr=%08h pc=%08h we=%0d rd=%0d data=%08h jump=%0d target=%08h mem=%0d ready@%0d",
                 name, instr, pc, we_n, wa, wd, jmp_n, tgt, req_n, ready_cyc);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_data  = '0;
        bus.instr_pc    = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
        rf_mem[1]  = 32'd5;
        rf_mem[2]  = 32'd7;
        rf_mem[6]  = 32'h10;
        rf_mem[10] = 32'h8000_0000;

        repeat (2) @(negedge clk);
        check_val("reset.instr_ready", 32'(bus.instr_ready), 32'd1);
        check_val("reset.rf_we", 32'(bus.rf_we), 32'd0);
        check_val("reset.mem_req", 32'(bus.mem_req), 32'd0);
        check_val("reset.pc_jump_en", 32'(bus.pc_jump_en), 32'd0);
        check_val("reset.illegal", 32'(bus.illegal_instr), 32'd0);
        check_val("reset.retired", bus.instr_retired, 32'd0);
        check_val("reset.pc_target", bus.pc_target, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        exp_q.push_back(mk_exp(0, 1, 5'd5, 32'hFFFF_FFFF, 0, 0, 5, 0, 0, 0, 0, 0, 1, 8'd0));
        run_instr("addi", 32'hFFF0_0293, 32'h0, 0, 0);
        exp_q.push_back(mk_exp(0, 1, 5'd3, 32'hFFFF_FFFE, 0, 0, 5, 0, 0, 0, 0, 0, 1, 8'd1));
        run_instr("sub", 32'h4020_81B3, 32'h4, 0, 0);
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 8'd0));
        run_instr("add_x0", 32'h0020_8033, 32'h8, 0, 0);
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("beq_nt", 32'hFE20_8CE3, 32'h100, 0, 0);
        rf_mem[2] = 32'd5;
        exp_q.push_back(mk_exp(0, 0, 0, 0, 1, 32'hF8, 5, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("beq_t", 32'hFE20_8CE3, 32'h100, 0, 0);
        rf_mem[2] = 32'h200;
        exp_q.push_back(mk_exp(0, 1, 5'd1, 32'h44, 1, 32'h202, 5, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("jalr", 32'h0031_00E7, 32'h40, 0, 0);
        exp_q.push_back(mk_exp(0, 1, 5'd4, 32'hFFFF_FF80, 0, 0, 9, 4, 0, 2'd0, 32'h10, 0, 0, 8'd0));
        run_instr("lb", 32'h0003_0203, 32'h50, 3, 32'h80);
        exp_q.push_back(mk_exp(0, 1, 5'd4, 32'h80, 0, 0, 6, 1, 0, 2'd0, 32'h10, 0, 0, 8'd0));
        run_instr("lbu", 32'h0003_4203, 32'h54, 0, 32'h80);
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0, 0, 7, 2, 1, 2'd2, 32'h18, 32'h200, 0, 8'd0));
        run_instr("sw", 32'h0023_2423, 32'h58, 1, 0);
        exp_q.push_back(mk_exp(0, 1, 5'd7, 32'h1234_5000, 0, 0, 5, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("lui", 32'h1234_53B7, 32'h5C, 0, 0);
        exp_q.push_back(mk_exp(0, 1, 5'd11, 32'h1300, 0, 0, 5, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("auipc", 32'h0000_1597, 32'h300, 0, 0);
        exp_q.push_back(mk_exp(0, 1, 5'd1, 32'h84, 1, 32'h90, 5, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("jal", 32'h0100_00EF, 32'h80, 0, 0);
        exp_q.push_back(mk_exp(0, 1, 5'd9, 32'hF800_0000, 0, 0, 5, 0, 0, 0, 0, 0, 1, 8'd8));
        run_instr("srai", 32'h4045_5493, 32'h90, 0, 0);
        exp_q.push_back(mk_exp(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("ill_op", 32'h0000_007F, 32'h94, 0, 0);
        exp_q.push_back(mk_exp(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 8'd0));
        run_instr("ill_f7", 32'h4020_F1B3, 32'h98, 0, 0);

        // abort a load mid-MEM with an asynchronous reset
        bus.instr_valid = 1'b1;
        bus.instr_data  = 32'h0003_0203;
        bus.instr_pc    = 32'h60;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 10 && seen == 0; k++) begin
                @(negedge clk);
                if (bus.mem_req) seen = 1;
            end
            check_val("abort.mem_req_seen", 32'(seen), 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        check_val("abort.mem_req", 32'(bus.mem_req), 32'd0);
        check_val("abort.instr_ready", 32'(bus.instr_ready), 32'd1);
        check_val("abort.rf_we", 32'(bus.rf_we), 32'd0);
        check_val("abort.pc_jump_en", 32'(bus.pc_jump_en), 32'd0);
        check_val("abort.retired", bus.instr_retired, 32'd0);
        check_val("abort.mem_addr", bus.mem_addr, 32'd0);
        $display("TXN %-8s instr=%08h pc=%08h reset during MEM", "abort", 32'h0003_0203, 32'h60);
        exp_retired = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk_exp(0, 1, 5'd5, 32'hFFFF_FFFF, 0, 0, 5, 0, 0, 0, 0, 0, 1, 8'd0));
        run_instr("addi_rs", 32'hFFF0_0293, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
